mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit with HI/LO registers for the pipelined CPU's EX stage.
//  Performs real radix-2 shift-add multiplication and restoring division, one bit per cycle.
//  Adds multiply-accumulate (MADD/MADDU/MSUB/MSUBU) and a flush input that aborts an
//  in-flight operation when an exception or interrupt arrives.
//  The stall unit holds any HI/LO-dependent instruction in ID while busy=1.
// PARAMETERS
//  WIDTH   32  operand / HI / LO width; must be even and >= 4
// PORTS
//  clk     in   1      system clock, rising edge
//  reset   in   1      asynchronous, active-high; clears all state
//  start   in   1      launch op (ops 0-3, 8-11); sampled at posedge
//  op      in   4      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO,8 MADD,9 MADDU,10 MSUB,11 MSUBU
//  src1    in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//  src2    in   WIDTH  rt operand (multiplier / divisor)
//  flush   in   1      abort in-flight op; HI/LO keep their pre-op values
//  rdata   out  WIDTH  combinational: HI if op==6, LO if op==7, else 0
//  busy    out  1      operation in progress
//  done    out  1      1-cycle pulse on the cycle after HI/LO are updated by a completed op
// BEHAVIOUR
//  Reset (async): HI=0, LO=0, busy=0, done=0, FSM=IDLE, counter=0, internal operand regs=0.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start=1 with op in {0-3, 8-11} latches operands, op and |src1|/|src2| (for signed ops),
//     sets cnt=0, goes to CALC. Any other op with start=1 is ignored.
//   CALC: one shift-add (mul) or one trial-subtract (div) step per cycle;
//     after WIDTH steps (cnt==WIDTH-1) goes to FIX.
//   FIX: applies sign correction; for MADD/MSUB adds/subtracts the 2*WIDTH product to/from {HI,LO}
//     (wraps modulo 2^(2*WIDTH)); writes HI/LO; goes to IDLE; done=1 next cycle.
//  Latency: start sampled at edge T -> busy=1 from T to T+WIDTH+1 -> HI/LO valid after edge T+WIDTH+1.
//   Total busy cycles = WIDTH+1 (33 at WIDTH=32), identical for all ops.
//  Multiply: {HI,LO} = full 2*WIDTH product. Signed: negate if operand signs differ.
//  Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//  Divide by zero (src2==0): no trap; HI=src1, LO={WIDTH{1'b1}}, same latency.
//  Signed overflow (MIN / -1): LO=MIN, HI=0.
//  MTHI/MTLO (op 4/5): when busy=0, HI<=src1 / LO<=src1 on the next edge; start is not required.
//   Ignored while busy=1.
//  start while busy=1 is ignored; the in-flight op is not disturbed. Compiler/stall unit guarantees no such issue.
//  flush=1: in any state -> IDLE next edge, busy=0, no HI/LO write, done stays 0.
//   flush and start in the same cycle while IDLE: flush wins and no op launches.
//   flush in FIX: HI/LO write is suppressed.
//  rdata is purely combinational from op and the HI/LO registers; it does not depend on busy
//   (stall logic prevents reads while busy).
//  reset mid-operation: immediate abort; all state returns to reset values.
// TESTING (WIDTH=32)
//  MULT src1=0xFFFFFFFE(-2), src2=3 -> busy 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once.
//  DIV src1=-7, src2=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU 7/0 -> HI=7, LO=0xFFFFFFFF.
//  MTHI 1, MTLO 0xFFFFFFFF, then MADDU 1*1 -> HI=2, LO=0; MSUB 1*1 from {0,0} -> HI=LO=0xFFFFFFFF.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=1; second start at cycle 5 ignored; MTLO during busy ignored.
//  MULT launched, flush at cycle 10 -> busy=0 next edge, HI/LO unchanged, no done; new op launches normally.
//  Async reset asserted mid-DIV, off clock edge -> busy=0, HI=LO=0 immediately; MFHI/MFLO read 0.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the iterative MDU.
// The CPU side drives the operation; the MDU returns status and read data.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             flush;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             done;

    modport master (
        output start, op, src1, src2, flush,
        input  rdata, busy, done
    );

    modport slave (
        input  start, op, src1, src2, flush,
        output rdata, busy, done
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO and MAC.
// One bit per cycle; a flush aborts without touching HI/LO.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mdu_iter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_src1;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;

    logic w_launch;
    logic w_step;
    logic w_write;
    logic w_mt;
    logic w_busy;

    // Operand decode on the incoming request
    logic             w_op_ok;
    logic             w_sgn_in;
    logic             w_div_in;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;

    assign w_op_ok  = (bus.op <= 4'd3) || (bus.op >= 4'd8 && bus.op <= 4'd11);
    assign w_sgn_in = ~bus.op[0];
    assign w_div_in = (bus.op[3:1] == 3'b001);
    assign w_neg1   = w_sgn_in & bus.src1[WIDTH-1];
    assign w_neg2   = w_sgn_in & bus.src2[WIDTH-1];
    assign w_abs1   = w_neg1 ? -bus.src1 : bus.src1;
    assign w_abs2   = w_neg2 ? -bus.src2 : bus.src2;

    // One iteration of shift-add and of restoring division
    logic               w_is_div;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_nx;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_nx;

    assign w_is_div = (r_op[3:1] == 3'b001);
    assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_mul_nx = r_acc[0] ? {w_madd, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};
    assign w_trial  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff   = w_trial - {1'b0, r_b};
    assign w_ge     = (w_trial >= {1'b0, r_b});
    assign w_div_nx = w_ge ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                           : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Sign correction and accumulate
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_hilo;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_res;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_hilo = {r_hi, r_lo};
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res = w_prod;
        unique case (r_op)
            4'd2, 4'd3: begin
                if (r_b == '0) w_res = {r_src1, {WIDTH{1'b1}}};
                else           w_res = {w_rem, w_quo};
            end
            4'd8, 4'd9:   w_res = w_hilo + w_prod;
            4'd10, 4'd11: w_res = w_hilo - w_prod;
            default:      w_res = w_prod;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (bus.start && w_op_ok) w_next = S_CALC;
                S_CALC: if (r_cnt == CW'(WIDTH-1)) w_next = S_FIX;
                S_FIX:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy   = 1'b0;
        w_launch = 1'b0;
        w_step   = 1'b0;
        w_write  = 1'b0;
        w_mt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_launch = bus.start & w_op_ok & ~bus.flush;
                w_mt     = ~bus.flush & (bus.op == 4'd4 || bus.op == 4'd5);
            end
            S_CALC: begin
                w_busy = 1'b1;
                w_step = ~bus.flush;
            end
            S_FIX: begin
                w_busy  = 1'b1;
                w_write = ~bus.flush;
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_src1  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_launch) begin
                r_a     <= w_abs1;
                r_b     <= w_abs2;
                r_src1  <= bus.src1;
                r_op    <= bus.op;
                r_cnt   <= '0;
                r_neg_q <= w_neg1 ^ w_neg2;
                r_neg_r <= w_neg1;
                r_acc   <= {{WIDTH{1'b0}}, (w_div_in ? w_abs1 : w_abs2)};
            end else if (w_step) begin
                r_acc <= w_is_div ? w_div_nx : w_mul_nx;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_write) begin
                {r_hi, r_lo} <= w_res;
            end else if (w_mt) begin
                if (bus.op == 4'd4) r_hi <= bus.src1;
                else                r_lo <= bus.src1;
            end
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = r_done;
    assign bus.rdata = (bus.op == 4'd6) ? r_hi :
                       (bus.op == 4'd7) ? r_lo : '0;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at WIDTH=32.
// Each task drives one scenario and checks results against fixed values.
module tb_mdu_iter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src1  = a;
        bus.src2  = b;
        tick();
        bus.start = 1'b0;
        bus.op    = 4'd7;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic write_hl(input logic [3:0] o, input logic [31:0] v);
        bus.op   = o;
        bus.src1 = v;
        tick();
        bus.op = 4'd7;
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        bus.op = 4'd6;
        #1;
        hi = bus.rdata;
        bus.op = 4'd7;
        #1;
        lo = bus.rdata;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        read_hl(hi, lo);
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b exp 0", bus.busy);
        end
        n_chk++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b exp 0", bus.done);
        end
        n_chk++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h_%h exp 0_0", hi, lo);
        end
    endtask

    task automatic test_mult();
        int c;
        logic [31:0] hi, lo;
        issue(4'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle(c);
        n_chk++;
        if (c !== 33) begin
            n_fail++;
            $display("FAIL mult_busy_cycles: got %0d exp 33", c);
        end
        n_chk++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_done: got %b exp 1", bus.done);
        end
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            n_fail++;
            $display("FAIL mult_hilo: got %h_%h exp ffffffff_fffffffa", hi, lo);
        end
        tick();
        n_chk++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_done_pulse: got %b exp 0", bus.done);
        end
    endtask

    task automatic test_div();
        int c;
        logic [31:0] hi, lo;
        issue(4'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(c);
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_signed: got %h_%h exp ffffffff_fffffffd", hi, lo);
        end
        issue(4'd3, 32'd7, 32'd0);
        wait_idle(c);
        n_chk++;
        if (c !== 33) begin
            n_fail++;
            $display("FAIL div0_cycles: got %0d exp 33", c);
        end
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL divu_by_zero: got %h_%h exp 00000007_ffffffff", hi, lo);
        end
        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(c);
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: got %h_%h exp 00000000_80000000", hi, lo);
        end
    endtask

    task automatic test_mac();
        int c;
        logic [31:0] hi, lo;
        write_hl(4'd4, 32'd1);
        write_hl(4'd5, 32'hFFFF_FFFF);
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'd1 || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL mthi_mtlo: got %h_%h exp 00000001_ffffffff", hi, lo);
        end
        issue(4'd9, 32'd1, 32'd1);
        wait_idle(c);
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'd2 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL maddu: got %h_%h exp 00000002_00000000", hi, lo);
        end
        write_hl(4'd4, 32'd0);
        write_hl(4'd5, 32'd0);
        issue(4'd10, 32'd1, 32'd1);
        wait_idle(c);
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL msub: got %h_%h exp ffffffff_ffffffff", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [31:0] hi, lo;
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.op    = 4'd0;
        bus.src1  = 32'd1;
        bus.src2  = 32'd1;
        tick();
        bus.start = 1'b0;
        bus.op    = 4'd5;
        bus.src1  = 32'h0000_1234;
        tick();
        bus.op = 4'd7;
        wait_idle(c);
        n_chk++;
        if (c + 6 !== 33) begin
            n_fail++;
            $display("FAIL b2b_cycles: got %0d exp 33", c + 6);
        end
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin
            n_fail++;
            $display("FAIL b2b_multu: got %h_%h exp fffffffe_00000001", hi, lo);
        end
    endtask

    task automatic test_flush();
        int c;
        logic [31:0] hi, lo;
        write_hl(4'd4, 32'h11);
        write_hl(4'd5, 32'h22);
        issue(4'd0, 32'd5, 32'd5);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: got %b exp 0", bus.busy);
        end
        c = 0;
        repeat (3) begin
            if (bus.done) c++;
            tick();
        end
        n_chk++;
        if (c !== 0) begin
            n_fail++;
            $display("FAIL flush_done: got %0d pulses exp 0", c);
        end
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            n_fail++;
            $display("FAIL flush_hilo: got %h_%h exp 00000011_00000022", hi, lo);
        end
        bus.flush = 1'b1;
        issue(4'd0, 32'd2, 32'd2);
        bus.flush = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start: got busy %b exp 0", bus.busy);
        end
        issue(4'd1, 32'd3, 32'd4);
        wait_idle(c);
        read_hl(hi, lo);
        n_chk++;
        if (c !== 33 || hi !== 32'd0 || lo !== 32'd12) begin
            n_fail++;
            $display("FAIL post_flush: got %0d %h_%h exp 33 00000000_0000000c", c, hi, lo);
        end
    endtask

    task automatic test_async_reset();
        int c;
        logic [31:0] hi, lo;
        issue(4'd2, 32'd100, 32'd7);
        repeat (7) tick();
        #3;
        reset = 1'b1;
        #1;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_busy: got %b%b exp 00", bus.busy, bus.done);
        end
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_hilo: got %h_%h exp 0_0", hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        issue(4'd3, 32'd100, 32'd7);
        wait_idle(c);
        read_hl(hi, lo);
        n_chk++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            n_fail++;
            $display("FAIL post_reset_divu: got %h_%h exp 00000002_0000000e", hi, lo);
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 4'd7;
        bus.src1  = '0;
        bus.src2  = '0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        test_mult();
        test_div();
        test_mac();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
